// File: rtl/toggle_port_ram.sv
// rtl/toggle_port_ram.sv - toggle-handshake responder into a single-port block RAM with a stalling fetch port
module toggle_port_ram #(
    parameter int AW      = 15,
    parameter int LATENCY = 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic [15:0]   port_q,
    input  logic [AW-1:0] cpu_addr,
    output logic [15:0]   cpu_q,
    output logic          cpu_wait
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   a_q, a_d;
    logic [1:0]      ds_q, ds_d;
    logic            we_q, we_d;
    logic [15:0]     d_q, d_d;
    logic            snap_q, snap_d;
    logic            ack_q, ack_d;
    logic [15:0]     port_q_q, port_q_d;
    logic            wait_q, wait_d;
    logic [15:0]     hold_q, hold_d;
    logic [15:0]     rd_q;

    logic [15:0]     mem [0:(1<<AW)-1];
    logic            port_sel;
    logic [AW-1:0]   ram_addr;
    logic [1:0]      ram_be;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        ds_d     = ds_q;
        we_d     = we_q;
        d_d      = d_q;
        snap_d   = snap_q;
        ack_d    = ack_q;
        port_q_d = port_q_q;
        case (state_q)
            // DONE takes a waiting request straight away so back-to-back
            // accesses run at one per LATENCY+2 cycles.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (port_req != ack_q) begin
                    a_d     = port_a;
                    ds_d    = port_ds;
                    we_d    = port_we;
                    d_d     = port_d;
                    snap_d  = port_req;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    port_q_d = rd_q;
                end
                ack_d   = snap_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM sees the port address on the edge that enters ACCESS; every
    // other edge belongs to the fetch port.
    always_comb begin
        port_sel = (state_d == S_ACCESS);
        wait_d   = port_sel;
        ram_addr = port_sel ? a_q : cpu_addr;
        ram_be   = (port_sel && we_q && !reset) ? ds_q : 2'b00;
        hold_d   = cpu_q;
    end

    always_ff @(posedge clk_sys) begin
        if (ram_be[1]) begin
            mem[ram_addr][15:8] <= d_q[15:8];
        end
        if (ram_be[0]) begin
            mem[ram_addr][7:0] <= d_q[7:0];
        end
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            ds_q     <= '0;
            we_q     <= 1'b0;
            d_q      <= '0;
            snap_q   <= 1'b0;
            ack_q    <= 1'b0;
            port_q_q <= '0;
            wait_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            ds_q     <= ds_d;
            we_q     <= we_d;
            d_q      <= d_d;
            snap_q   <= snap_d;
            ack_q    <= ack_d;
            port_q_q <= port_q_d;
            wait_q   <= wait_d;
            hold_q   <= hold_d;
        end
    end

    // While the port owns the RAM output, the fetch port replays its last word.
    assign cpu_q    = wait_q ? hold_q : rd_q;
    assign cpu_wait = wait_q;
    assign port_ack = ack_q;
    assign port_q   = port_q_q;

endmodule

// File: doc/toggle_port_ram.md
# toggle_port_ram

Responder for the toggle-style `port_req`/`port_ack` handshake used by the ROM download controller and similar initiators. It accepts 16-bit word writes with byte-lane selects, and word reads, into an internal single-port block RAM. A free-running CPU fetch port reads the same RAM every cycle and stalls for one cycle whenever a handshake access uses the RAM. It sits on the `clk_sys` domain alongside `data_io` and stands in for an SDRAM port on boards or cores that keep ROM in BRAM.

## Interface
Parameters:
- `AW`, 15: word address width; RAM depth is 2^AW 16-bit words.
- `LATENCY`, 1: cycles from request capture to RAM access; legal range 1..15. Emulates SDRAM wait.

Ports:
- `clk_sys` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `port_req` in 1: request toggle. A request is pending while `port_req != port_ack`.
- `port_ack` out 1: acknowledge toggle. It is set equal to the captured `port_req` when the access completes.
- `port_a` in AW: word address, sampled at capture.
- `port_ds` in 2: byte lanes. [1] selects bits 15:8; [0] selects bits 7:0.
- `port_we` in 1: 1 = write, 0 = read.
- `port_d` in 16: write data.
- `port_q` out 16: read data, valid from the cycle `port_ack` changes.
- `cpu_addr` in AW: fetch address.
- `cpu_q` out 16: registered fetch data.
- `cpu_wait` out 1: high for the single cycle in which `cpu_q` holds instead of updating.

## Operation
State machine: IDLE, WAIT, ACCESS, DONE.
- IDLE
  - If `port_req != port_ack`: capture `port_a`, `port_ds`, `port_we`, `port_d` and `port_req` (as `req_snap`).
  - Load the counter with `LATENCY-1`. Go to WAIT.
- WAIT
  - Decrement the counter.
  - At 0, go to ACCESS. With `LATENCY=1`, WAIT lasts one cycle.
- ACCESS: RAM is driven by the captured request.
  - Write: only the lanes set in `ds` are written. `ds=00` writes nothing, but the access still completes and is acknowledged.
  - Read: the full word is read; `ds` is ignored.
  - Go to DONE.
- DONE
  - Reads: `port_q` <= RAM output. Writes: `port_q` holds its previous value.
  - `port_ack` <= `req_snap`. Go to IDLE.

Other rules:
- Requests are sampled only in IDLE. Address and data may change freely after capture.
- If `port_req` toggles again while busy, the mismatch remains after ack, and a second request is captured in IDLE using the then-current inputs.
  - A double toggle during busy makes `port_req` equal `req_snap`. This is treated as no new request.
- CPU port: every cycle except ACCESS, `cpu_q` <= RAM[`cpu_addr`] as a one-cycle registered read.
  - `cpu_wait` = 1 exactly on cycles where the RAM address is the port address, i.e. the cycle after ACCESS is presented.
- Reset
  - Outputs: `port_ack`=0, `port_q`=0, `cpu_q`=0, `cpu_wait`=0. State goes to IDLE and the counter clears.
  - RAM contents are not cleared.
  - Reset during WAIT abandons the request, and no write occurs.
  - Reset asserted on the ACCESS edge suppresses the write.
  - After reset, if `port_req`=1, the mismatch with `port_ack`=0 starts a fresh request.
- Address arithmetic is modulo 2^AW; there is no bounds check.

## Timing
- Capture at clock edge N.
- RAM access presented at edge N+LATENCY; write committed at that edge.
- `port_ack`/`port_q` update at edge N+LATENCY+1.
- Earliest next capture is edge N+LATENCY+2.
- Throughput: one access per LATENCY+2 cycles.
- `cpu_q` latency is 1 cycle from `cpu_addr`, extended to 2 when the read collides with ACCESS.
  - `cpu_wait` is high in the cycle `cpu_q` would otherwise have updated.
- A port write followed by a CPU read of the same address returns new data on the first non-stalled fetch after ACCESS.

## Test plan
- **Byte writes:** LATENCY=1, reset then toggle `req` with a=0x0010, ds=01, we=1, d=0xAB00|0x00CD. Then toggle with ds=10, d=0x1200.
  - `port_ack` follows each toggle 2 edges after capture.
  - A read of 0x0010 gives `port_q`=0x12CD.
- **ds=00 write:** ds=00 write to 0x0010 → ack toggles; a subsequent read still returns 0x12CD.
- **CPU stall:** `cpu_addr`=0x0010 held constant during a port write of 0xBEEF (ds=11).
  - `cpu_wait` pulses 1 cycle.
  - `cpu_q` changes 0x12CD→0xBEEF on the first non-stalled cycle after ACCESS.
- **LATENCY=4 timing:** ack exactly 5 edges after capture; next request captured no earlier than 6 edges after the previous capture.
- **Toggle while busy:**
  - One toggle during WAIT → two accesses; the second uses the inputs present at the second capture.
  - Two toggles during WAIT → exactly one access.
- **Reset mid-operation:**
  - `reset` in WAIT of a write to 0x0020 → RAM[0x0020] unchanged and `port_ack`=0.
  - With `port_req` held 1, a new access starts after release and completes with `port_ack`=1.
